// File: rtl/clasif_ctrl.sv
// Bean classifier: averages N_SAMPLES sensor readings and grades the bean
// into baja/media/alta, with sample timeout, abort and sticky error.
module clasif_ctrl #(
    parameter int N_SAMPLES = 4,
    parameter int TH_LOW    = 85,
    parameter int TH_HIGH   = 170,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic       sample_ready,
    output logic [1:0] estado,
    output logic       done,
    output logic       busy,
    output logic       error
);

    localparam int LOG2N = $clog2(N_SAMPLES);
    localparam int ACC_W = 8 + LOG2N;
    localparam int CNT_W = LOG2N + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [8:0]       TH_LO    = 9'(TH_LOW);
    localparam logic [8:0]       TH_HI    = 9'(TH_HIGH);

    localparam logic [1:0] G_BAJA  = 2'b00;
    localparam logic [1:0] G_MEDIA = 2'b01;
    localparam logic [1:0] G_ALTA  = 2'b10;
    localparam logic [1:0] G_NONE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        CALC,
        ERR
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] tmr;
    logic             accept;
    logic [8:0]       avg;
    logic [1:0]       grade;

    assign accept = sample_valid && sample_ready;
    assign avg    = 9'(acc >> LOG2N);

    always_comb begin
        grade = G_MEDIA;
        unique case (1'b1)
            (avg < TH_LO):  grade = G_BAJA;
            (avg >= TH_HI): grade = G_ALTA;
            default:        grade = G_MEDIA;
        endcase
    end

    // abort has priority over a last sample or an expiring timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            estado       <= G_NONE;
            done         <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            sample_ready <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            tmr          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= ACQ;
                        busy         <= 1'b1;
                        sample_ready <= 1'b1;
                        error        <= 1'b0;
                        acc          <= '0;
                        cnt          <= '0;
                        tmr          <= '0;
                    end
                end
                ACQ: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        sample_ready <= 1'b0;
                    end else if (accept) begin
                        acc <= acc + ACC_W'(sample);
                        cnt <= cnt + CNT_W'(1);
                        tmr <= '0;
                        if (cnt == CNT_LAST) begin
                            state        <= CALC;
                            sample_ready <= 1'b0;
                        end
                    end else if (tmr == TMR_LAST) begin
                        state        <= ERR;
                        sample_ready <= 1'b0;
                    end else if (tmr != '1) begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                CALC: begin
                    estado <= grade;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                ERR: begin
                    estado <= G_NONE;
                    error  <= 1'b1;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clasif_ctrl.sv
// Randomized self-checking bench for clasif_ctrl against a
// sum/average grading model kept in the bench.
module tb_clasif_ctrl;

    localparam int N   = 4;
    localparam int TL  = 85;
    localparam int TH  = 170;
    localparam int TMO = 1000;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       sample_valid;
    logic [7:0] sample;
    logic       sample_ready;
    logic [1:0] estado;
    logic       done;
    logic       busy;
    logic       error;

    int n_chk;
    int n_pass;
    int model_estado;

    clasif_ctrl #(
        .N_SAMPLES(N),
        .TH_LOW   (TL),
        .TH_HIGH  (TH),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .sample_valid(sample_valid),
        .sample      (sample),
        .sample_ready(sample_ready),
        .estado      (estado),
        .done        (done),
        .busy        (busy),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    endtask

    function automatic int grade_of(input int sum);
        int avg;
        avg = sum / N;
        if (avg < TL) return 0;
        if (avg >= TH) return 2;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 picks a random gap 0..4 before each sample
    task automatic classify(input int s0, input int s1, input int s2,
                            input int s3, input int gap,
                            input bit do_abort, input bit poke);
        int s[4];
        int sum;
        int exp_e;
        int g;
        s = '{s0, s1, s2, s3};
        sum = s0 + s1 + s2 + s3;
        exp_e = grade_of(sum);
        start = 1'b1;
        sample_valid = 1'($urandom % 2);
        sample = 8'($urandom);
        tick();
        start = 1'b0;
        sample_valid = 1'b0;
        chk("busy_acq", int'(busy), 1);
        chk("ready_acq", int'(sample_ready), 1);
        chk("err_clr", int'(error), 0);
        for (int i = 0; i < N; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
            for (int j = 0; j < g; j++) begin
                start = poke;
                tick();
                start = 1'b0;
            end
            sample_valid = 1'b1;
            sample = 8'(s[i]);
            abort = (i == N - 1) && do_abort;
            tick();
            sample_valid = 1'b0;
            abort = 1'b0;
        end
        if (do_abort) begin
            chk("abort_busy", int'(busy), 0);
            chk("abort_ready", int'(sample_ready), 0);
            chk("abort_done0", int'(done), 0);
            tick();
            chk("abort_done1", int'(done), 0);
            chk("abort_estado", int'(estado), model_estado);
        end else begin
            chk("calc_ready", int'(sample_ready), 0);
            chk("calc_done", int'(done), 0);
            chk("calc_busy", int'(busy), 1);
            start = poke;
            abort = 1'($urandom % 2);
            tick();
            start = 1'b0;
            abort = 1'b0;
            chk("done_pulse", int'(done), 1);
            chk("estado", int'(estado), exp_e);
            chk("idle_busy", int'(busy), 0);
            chk("no_err", int'(error), 0);
            model_estado = exp_e;
            tick();
            chk("done_end", int'(done), 0);
            chk("estado_hold", int'(estado), model_estado);
        end
    endtask

    task automatic timeout_run();
        int pulses;
        int when;
        pulses = 0;
        when = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            sample = 8'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        for (int k = 1; k <= TMO + 3; k++) begin
            tick();
            if (done) begin
                pulses++;
                if (when < 0) when = k;
            end
        end
        chk("to_pulses", pulses, 1);
        chk("to_when", when, TMO + 1);
        chk("to_estado", int'(estado), 3);
        chk("to_error", int'(error), 1);
        chk("to_busy", int'(busy), 0);
        model_estado = 3;
        tick();
        tick();
        chk("err_sticky", int'(error), 1);
    endtask

    task automatic reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample = 8'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_estado", int'(estado), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(sample_ready), 0);
        chk("rst_done", int'(done), 0);
        model_estado = 3;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_nodone", int'(done), 0);
        end
        reset = 1'b1;
    endtask

    int v;

    initial begin
        n_chk = 0;
        n_pass = 0;
        model_estado = 3;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sample_valid = 1'b0;
        sample = 8'd0;
        #12;
        chk("r_estado", int'(estado), 3);
        chk("r_done", int'(done), 0);
        chk("r_busy", int'(busy), 0);
        chk("r_error", int'(error), 0);
        chk("r_ready", int'(sample_ready), 0);
        tick();
        reset = 1'b1;

        classify(10, 20, 30, 40, 0, 1'b0, 1'b0);
        classify(100, 120, 140, 160, 3, 1'b0, 1'b0);
        classify(170, 170, 170, 170, 0, 1'b0, 1'b0);
        classify(169, 169, 169, 169, 0, 1'b0, 1'b0);
        classify(85, 85, 85, 85, 1, 1'b0, 1'b0);
        classify(84, 84, 84, 84, 0, 1'b0, 1'b0);
        classify(255, 255, 255, 255, 0, 1'b0, 1'b0);
        classify(10, 20, 30, 40, 2, 1'b1, 1'b1);

        timeout_run();
        classify(200, 210, 220, 230, -1, 1'b0, 1'b1);

        reset_mid();
        classify(90, 100, 110, 120, 0, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            int r[4];
            v = int'($urandom_range(60, 190));
            for (int i = 0; i < 4; i++) begin
                if ($urandom % 3 == 0) r[i] = int'($urandom_range(0, 255));
                else r[i] = v + int'($urandom_range(0, 6)) - 3;
            end
            classify(r[0], r[1], r[2], r[3], -1,
                     1'($urandom % 6 == 0), 1'($urandom % 2));
            abort = 1'($urandom % 2);
            tick();
            abort = 1'b0;
            chk("idle_abort", int'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
